counter_seq_ctrl: RTL and testbench
===================================

COUNTER_SEQ_CTRL -- requirements
Module: counter_seq_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_WIDTH, default 8, giving the width of the managed counter, the load value and the count output.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 Port clk, input, 1: the single clock; all state updates occur on its rising edge.
REQ-004 Port reset, input, 1: asynchronous active-high reset.
REQ-005 Port start, input, 1: request a new counting run; sampled only in IDLE.
REQ-006 Port load_val, input, CNT_WIDTH: run length N; captured on an accepted start.
REQ-007 Port dir, input, 1: direction, captured on an accepted start; 1 = count up 0 to N, 0 = count down N to 0.
REQ-008 Port auto_reload, input, 1: captured on an accepted start; 1 = restart the run automatically after each completion.
REQ-009 Port pause, input, 1: level; freezes the count while high in RUN or PAUSED.
REQ-010 Port abort, input, 1: level; terminates any active run.
REQ-011 Port busy, output, 1: high in every state except IDLE.
REQ-012 Port done, output, 1: single-cycle completion pulse.
REQ-013 Port count, output, CNT_WIDTH: current counter value.

Function
REQ-014 The FSM SHALL have exactly these states: IDLE, LOAD, RUN, PAUSED, DONE.
REQ-015 IDLE with start=1 -> LOAD; load_val, dir and auto_reload are captured into internal config registers on this edge; count is unchanged.
REQ-016 Inputs load_val, dir and auto_reload changing after capture SHALL have no effect until the next accepted start.
REQ-017 start outside IDLE SHALL be ignored; it is not queued.
REQ-018 LOAD -> RUN unconditionally; count is loaded with N if dir=0, or with 0 if dir=1.
REQ-019 Terminal value T is 0 when dir=0 and N when dir=1.
REQ-020 RUN with count==T -> DONE; count is not stepped on that edge.
REQ-021 RUN with count!=T and pause=0: count steps by exactly 1 toward T; count never wraps.
REQ-022 RUN with pause=1 (count!=T) -> PAUSED; count holds.
REQ-023 PAUSED stays in PAUSED while pause=1 with count held; pause=0 -> RUN, and stepping resumes on the following edge.
REQ-024 In RUN, the terminal check SHALL take priority over pause.
REQ-025 DONE lasts exactly one cycle; it goes to LOAD if the captured auto_reload=1, otherwise to IDLE.
REQ-026 done SHALL be high only while in DONE and is a Moore output.
REQ-027 abort=1 in LOAD, RUN, PAUSED or DONE SHALL force IDLE on the next edge, with count held and no further done pulse; abort has priority over pause, start and terminal detection.
REQ-028 Timing: with start sampled at edge k, count=N (down) or 0 (up) after edge k+1, count=T after edge k+1+N, and done high during cycle k+2+N.
REQ-029 Timing: for N=0, done SHALL be high during cycle k+2.
REQ-030 Timing: with auto_reload=1, successive done pulses SHALL be exactly N+3 cycles apart, assuming no pause and no abort.
REQ-031 Timing: each cycle spent in PAUSED delays done by exactly one cycle.
REQ-032 Boundary: N=2^CNT_WIDTH-1 with dir=1 SHALL reach the all-ones value without overflow.

Reset
REQ-033 reset=1 SHALL force, asynchronously and regardless of clk: state=IDLE, count=0, busy=0, done=0, and all config registers to 0.
REQ-034 Reset asserted mid-run SHALL discard the run; after release the block waits in IDLE for a new start.
REQ-035 A start presented during the first edge after reset deassertion SHALL be accepted normally.

Verification
REQ-036 Scenario, one-shot countdown: CNT_WIDTH=8, start with load_val=5, dir=0, auto_reload=0 at edge k -> count 5,4,3,2,1,0 after edges k+1..k+6, done high only in cycle k+7, busy low from k+8.
REQ-037 Scenario, count-up with auto-reload: load_val=3, dir=1, auto_reload=1 -> count 0,1,2,3 then repeats, done pulses 6 cycles apart, busy stays high.
REQ-038 Scenario, pause: down run with load_val=4, pause high for 3 cycles while count=2 -> count holds at 2 for those cycles, done arrives 3 cycles later than without pause.
REQ-039 Scenario, abort and ignored start: abort at count=3 of a down run from 6 -> IDLE next edge, count stays 3, no done pulse; start pulses during the run have no effect.
REQ-040 Scenario, boundaries: load_val=0 gives done in cycle k+2; load_val=255 with dir=1 reaches count=255 and then done, with no wrap.
REQ-041 Scenario, reset mid-run: reset asserted mid-run between clock edges -> count=0, busy=0 immediately; a new start after release behaves as in REQ-036.

Source files
------------

// File: rtl/counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : counter_seq_ctrl
//  Purpose  : Sequenced up/down run counter with pause, abort and auto-reload.
//  Revision : 1.0 - initial release
// ============================================================================
module counter_seq_ctrl #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] load_val,
    input  logic                 dir,
    input  logic                 auto_reload,
    input  logic                 pause,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] count
);

    localparam logic [CNT_WIDTH-1:0] c_one = CNT_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RUN    = 3'd2,
        S_PAUSED = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_WIDTH-1:0]   r_count;
    logic [CNT_WIDTH-1:0]   w_count_nxt;
    logic [CNT_WIDTH-1:0]   r_cfg_n;
    logic                   r_cfg_dir;
    logic                   r_cfg_auto;
    logic                   w_capture;
    logic [CNT_WIDTH-1:0]   w_term_val;
    logic                   w_at_term;

    // Up runs end at N, down runs end at 0.
    assign w_term_val = r_cfg_dir ? r_cfg_n : '0;
    assign w_at_term  = (r_count == w_term_val);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_cfg_n    <= '0;
            r_cfg_dir  <= 1'b0;
            r_cfg_auto <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            if (w_capture) begin
                r_cfg_n    <= load_val;
                r_cfg_dir  <= dir;
                r_cfg_auto <= auto_reload;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_capture   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_LOAD;
                    w_capture   = 1'b1;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_RUN;
                    w_count_nxt = r_cfg_dir ? '0 : r_cfg_n;
                end
            end
            S_RUN: begin
                // Abort beats terminal detection, which beats pause.
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_at_term) begin
                    w_state_nxt = S_DONE;
                end else if (pause) begin
                    w_state_nxt = S_PAUSED;
                end else begin
                    w_count_nxt = r_cfg_dir ? (r_count + c_one) : (r_count - c_one);
                end
            end
            S_PAUSED: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (!pause) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_DONE: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = r_cfg_auto ? S_LOAD : S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy  = (r_state != S_IDLE);
    assign done  = (r_state == S_DONE);
    assign count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_counter_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_counter_seq_ctrl
//  Purpose  : Directed-vector scoreboard bench for counter_seq_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_counter_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] load_val;
    logic       dir;
    logic       auto_reload;
    logic       pause;
    logic       abort;
    logic       busy;
    logic       done;
    logic [7:0] count;

    typedef struct packed {
        logic [7:0] c;
        logic       b;
        logic       d;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    counter_seq_ctrl #(.CNT_WIDTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .load_val    (load_val),
        .dir         (dir),
        .auto_reload (auto_reload),
        .pause       (pause),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Queue the outputs expected after the coming rising edge, then move on.
    task automatic exp(input int c, input bit b, input bit d);
        exp_t e;
        e.c = 8'(c);
        e.b = b;
        e.d = d;
        q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: outputs are presented once per cycle, sampled just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("count", int'(count), int'(e.c));
                chk("busy",  int'(busy),  int'(e.b));
                chk("done",  int'(done),  int'(e.d));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // One-shot countdown from 5; config inputs are scrambled after capture.
    task automatic run_down5();
        start = 1'b1; load_val = 8'd5; dir = 1'b0; auto_reload = 1'b0;
        exp(0, 1, 0);
        start = 1'b0; load_val = 8'd99; dir = 1'b1; auto_reload = 1'b1;
        for (int i = 5; i >= 0; i--) exp(i, 1, 0);
        exp(0, 1, 1);
        exp(0, 0, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; load_val = '0; dir = 1'b0;
        auto_reload = 1'b0; pause = 1'b0; abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_count", int'(count), 0);
        chk("rst_busy",  int'(busy),  0);
        chk("rst_done",  int'(done),  0);

        // One-shot countdown, start on first edge after reset release
        reset = 1'b0;
        run_down5();

        // Count-up with auto-reload, abort while in DONE
        start = 1'b1; load_val = 8'd3; dir = 1'b1; auto_reload = 1'b1;
        exp(0, 1, 0);
        start = 1'b0; load_val = 8'd7; dir = 1'b0; auto_reload = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) exp(i, 1, 0);
            exp(3, 1, 1);
            if (r == 0) exp(3, 1, 0);
        end
        abort = 1'b1;
        exp(3, 0, 0);
        abort = 1'b0;
        exp(3, 0, 0);

        // Pause at count 2, then pause held during terminal cycle
        start = 1'b1; load_val = 8'd4; dir = 1'b0; auto_reload = 1'b0;
        exp(3, 1, 0);
        start = 1'b0;
        exp(4, 1, 0);
        exp(3, 1, 0);
        exp(2, 1, 0);
        pause = 1'b1;
        exp(2, 1, 0);
        exp(2, 1, 0);
        pause = 1'b0;
        exp(2, 1, 0);
        exp(1, 1, 0);
        exp(0, 1, 0);
        pause = 1'b1;
        exp(0, 1, 1);
        pause = 1'b0;
        exp(0, 0, 0);

        // Abort mid-run with ignored start pulses
        start = 1'b1; load_val = 8'd6; dir = 1'b0; auto_reload = 1'b0;
        exp(0, 1, 0);
        start = 1'b0;
        exp(6, 1, 0);
        start = 1'b1; load_val = 8'd1;
        exp(5, 1, 0);
        start = 1'b0;
        exp(4, 1, 0);
        start = 1'b1;
        exp(3, 1, 0);
        start = 1'b0; abort = 1'b1;
        exp(3, 0, 0);
        abort = 1'b0;
        exp(3, 0, 0);
        exp(3, 0, 0);

        // N=0: done two cycles after start
        start = 1'b1; load_val = 8'd0; dir = 1'b0; auto_reload = 1'b0;
        exp(3, 1, 0);
        start = 1'b0;
        exp(0, 1, 0);
        exp(0, 1, 1);
        exp(0, 0, 0);

        // N=255 counting up reaches all-ones without wrapping
        start = 1'b1; load_val = 8'd255; dir = 1'b1; auto_reload = 1'b0;
        exp(0, 1, 0);
        start = 1'b0;
        for (int i = 0; i < 256; i++) exp(i, 1, 0);
        exp(255, 1, 1);
        exp(255, 0, 0);

        // Asynchronous reset between edges mid-run
        start = 1'b1; load_val = 8'd5; dir = 1'b0; auto_reload = 1'b0;
        exp(255, 1, 0);
        start = 1'b0;
        exp(5, 1, 0);
        exp(4, 1, 0);
        #2 reset = 1'b1;
        #1;
        chk("arst_count", int'(count), 0);
        chk("arst_busy",  int'(busy),  0);
        chk("arst_done",  int'(done),  0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_hold_busy", int'(busy), 0);
        reset = 1'b0;
        run_down5();

        chk("drain", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
